// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, header
// field layout and the default source tags.
package uart_tx_arbiter_pkg;

    localparam int PAYLOAD_W   = 48;
    localparam int HDR_ID_W    = 2;
    localparam int HDR_SEQ_W   = 6;
    localparam int HDR_W       = HDR_ID_W + HDR_SEQ_W;
    localparam int FRAME_W     = HDR_W + PAYLOAD_W;
    localparam int HDR_SEQ_LSB = 0;
    localparam int HDR_ID_LSB  = HDR_SEQ_LSB + HDR_SEQ_W;

    localparam logic [HDR_ID_W-1:0] DEFAULT_ADS1292_ID = 2'b01;
    localparam logic [HDR_ID_W-1:0] DEFAULT_MPR121_ID  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    typedef enum logic {
        SRC_ADS1292 = 1'b0,
        SRC_MPR121  = 1'b1
    } src_sel_t;

    // Header byte: source tag in the upper bits, per-source sequence below.
    function automatic logic [HDR_W-1:0] make_header(
        input logic [HDR_ID_W-1:0]  id,
        input logic [HDR_SEQ_W-1:0] seq
    );
        logic [HDR_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_ID_LSB +: HDR_ID_W]   = id;
        hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/uart_tx_src_buffer.sv
// One-deep capture buffer for a single frame source: holds the payload
// until the arbiter sends it, acknowledges the source one cycle after the
// capture, and keeps the source's running frame sequence number.
module uart_tx_src_buffer
    import uart_tx_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PAYLOAD_W-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ack,
    input  logic                 release_frame,
    output logic [PAYLOAD_W-1:0] buf_data,
    output logic                 pending,
    output logic [HDR_SEQ_W-1:0] seq
);

    logic capture;

    // A held request is taken only into an empty buffer, and not while the
    // ack for the previous capture is still out (the source has not yet
    // seen it and dropped valid). A buffer being released is still pending,
    // so it cannot refill in the same cycle.
    always_comb begin
        capture = frame_valid && !pending && !frame_ack;
    end

    // Capture register, pending flag, one-cycle ack and sequence counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data  <= '0;
            pending   <= 1'b0;
            frame_ack <= 1'b0;
            seq       <= '0;
        end else begin
            frame_ack <= capture;
            if (capture) begin
                buf_data <= frame_data;
                pending  <= 1'b1;
            end else if (release_frame) begin
                pending  <= 1'b0;
            end
            if (release_frame) begin
                seq <= seq + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Merges ADS1292 and MPR121 frames onto a single UART transmit stream,
// tagging each with a {source, sequence} header byte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [HDR_ID_W-1:0] P_ADS1292_ID       = DEFAULT_ADS1292_ID,
    parameter logic [HDR_ID_W-1:0] P_MPR121_ID        = DEFAULT_MPR121_ID,
    parameter bit                  P_ADS1292_PRIORITY = 1'b0
)(
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_ENABLE,
    input  logic [PAYLOAD_W-1:0] i_ADS1292_FRAME_DATA,
    input  logic                 i_ADS1292_FRAME_VALID,
    output logic                 o_ADS1292_FRAME_ACK,
    input  logic [PAYLOAD_W-1:0] i_MPR121_FRAME_DATA,
    input  logic                 i_MPR121_FRAME_VALID,
    output logic                 o_MPR121_FRAME_ACK,
    output logic [FRAME_W-1:0]   o_UART_DATA_TX,
    output logic                 o_UART_DATA_TX_VALID,
    input  logic                 i_UART_DATA_TX_READY,
    output logic                 o_ARB_BUSY
);

    arb_state_t             state, state_next;
    src_sel_t               grant, grant_next;
    src_sel_t               last_grant, last_grant_next;
    src_sel_t               pick;
    logic [FRAME_W-1:0]     tx_data_next;

    logic                   ads_release, mpr_release;
    logic                   ads_pending, mpr_pending;
    logic [PAYLOAD_W-1:0]   ads_buf, mpr_buf;
    logic [HDR_SEQ_W-1:0]   ads_seq, mpr_seq;

    uart_tx_src_buffer u_ads_buf (
        .clk           (i_CLK),
        .rst           (i_RST),
        .frame_data    (i_ADS1292_FRAME_DATA),
        .frame_valid   (i_ADS1292_FRAME_VALID),
        .frame_ack     (o_ADS1292_FRAME_ACK),
        .release_frame (ads_release),
        .buf_data      (ads_buf),
        .pending       (ads_pending),
        .seq           (ads_seq)
    );

    uart_tx_src_buffer u_mpr_buf (
        .clk           (i_CLK),
        .rst           (i_RST),
        .frame_data    (i_MPR121_FRAME_DATA),
        .frame_valid   (i_MPR121_FRAME_VALID),
        .frame_ack     (o_MPR121_FRAME_ACK),
        .release_frame (mpr_release),
        .buf_data      (mpr_buf),
        .pending       (mpr_pending),
        .seq           (mpr_seq)
    );

    // Choose which pending source to serve next: on a tie, either strict
    // ADS1292 priority or alternate away from the last source served.
    always_comb begin
        pick = SRC_MPR121;
        if (ads_pending && mpr_pending) begin
            if (P_ADS1292_PRIORITY) begin
                pick = SRC_ADS1292;
            end else begin
                pick = (last_grant == SRC_ADS1292) ? SRC_MPR121 : SRC_ADS1292;
            end
        end else if (ads_pending) begin
            pick = SRC_ADS1292;
        end
    end

    // Arbiter FSM: grant and load a frame from IDLE, then hold it in SEND
    // until the UART accepts it; ENABLE only gates new grants.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        tx_data_next    = o_UART_DATA_TX;
        ads_release     = 1'b0;
        mpr_release     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_ENABLE && (ads_pending || mpr_pending)) begin
                    grant_next      = pick;
                    last_grant_next = pick;
                    if (pick == SRC_ADS1292) begin
                        tx_data_next = {make_header(P_ADS1292_ID, ads_seq), ads_buf};
                    end else begin
                        tx_data_next = {make_header(P_MPR121_ID, mpr_seq), mpr_buf};
                    end
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_UART_DATA_TX_READY) begin
                    if (grant == SRC_ADS1292) begin
                        ads_release = 1'b1;
                    end else begin
                        mpr_release = 1'b1;
                    end
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, grant bookkeeping and the registered outgoing frame.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state          <= ST_IDLE;
            grant          <= SRC_ADS1292;
            last_grant     <= SRC_MPR121;
            o_UART_DATA_TX <= '0;
        end else begin
            state          <= state_next;
            grant          <= grant_next;
            last_grant     <= last_grant_next;
            o_UART_DATA_TX <= tx_data_next;
        end
    end

    // Valid follows the registered state; busy also reflects waiting buffers.
    always_comb begin
        o_UART_DATA_TX_VALID = (state == ST_SEND);
        o_ARB_BUSY           = ads_pending || mpr_pending || (state == ST_SEND);
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a round-robin instance checked
// every cycle against a frame-level model, and a strict-priority instance
// checked against hand-computed frame sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 = round-robin instance, 1 = ADS1292-priority instance.
    // Source index 0 = ADS1292, 1 = MPR121.
    logic        rst     [2];
    logic        enable  [2];
    logic        ready   [2];
    logic [47:0] src_data  [2][2];
    logic        src_valid [2][2];
    logic        src_ack   [2][2];
    logic [55:0] tx_data  [2];
    logic        tx_valid [2];
    logic        busy     [2];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ads_ack_cnt = 0;

    uart_tx_arbiter #(.P_ADS1292_PRIORITY(1'b0)) dut_rr (
        .i_CLK                 (clk),
        .i_RST                 (rst[0]),
        .i_ENABLE              (enable[0]),
        .i_ADS1292_FRAME_DATA  (src_data[0][0]),
        .i_ADS1292_FRAME_VALID (src_valid[0][0]),
        .o_ADS1292_FRAME_ACK   (src_ack[0][0]),
        .i_MPR121_FRAME_DATA   (src_data[0][1]),
        .i_MPR121_FRAME_VALID  (src_valid[0][1]),
        .o_MPR121_FRAME_ACK    (src_ack[0][1]),
        .o_UART_DATA_TX        (tx_data[0]),
        .o_UART_DATA_TX_VALID  (tx_valid[0]),
        .i_UART_DATA_TX_READY  (ready[0]),
        .o_ARB_BUSY            (busy[0])
    );

    uart_tx_arbiter #(.P_ADS1292_PRIORITY(1'b1)) dut_pri (
        .i_CLK                 (clk),
        .i_RST                 (rst[1]),
        .i_ENABLE              (enable[1]),
        .i_ADS1292_FRAME_DATA  (src_data[1][0]),
        .i_ADS1292_FRAME_VALID (src_valid[1][0]),
        .o_ADS1292_FRAME_ACK   (src_ack[1][0]),
        .i_MPR121_FRAME_DATA   (src_data[1][1]),
        .i_MPR121_FRAME_VALID  (src_valid[1][1]),
        .o_MPR121_FRAME_ACK    (src_ack[1][1]),
        .o_UART_DATA_TX        (tx_data[1]),
        .o_UART_DATA_TX_VALID  (tx_valid[1]),
        .i_UART_DATA_TX_READY  (ready[1]),
        .o_ARB_BUSY            (busy[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [55:0] actual, input logic [55:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Frame-level model of the round-robin instance: which frames sit in
    // which buffer, who is on the wire, and the per-source sequence numbers.
    logic        m_pend [2];
    logic        m_ack  [2];
    logic [47:0] m_buf  [2];
    logic [5:0]  m_seq  [2];
    logic        m_sending;
    int          m_grant;
    int          m_last;
    logic [55:0] m_frame;
    logic [55:0] m_log [$];
    int          m_log_cyc [$];
    logic [1:0]  ids [2] = '{2'b01, 2'b10};

    always @(negedge clk) begin : model_check
        logic cap [2];
        int   g;
        if (rst[0]) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = 1'b0; m_ack[i] = 1'b0; m_buf[i] = '0; m_seq[i] = '0;
            end
            m_sending = 1'b0; m_grant = 0; m_last = 1; m_frame = '0;
            m_log.delete(); m_log_cyc.delete();
            checkOutput("rst_tx_valid", tx_valid[0], 56'd0);
            checkOutput("rst_tx_data",  tx_data[0],  56'd0);
            checkOutput("rst_busy",     busy[0],     56'd0);
            checkOutput("rst_ads_ack",  src_ack[0][0], 56'd0);
            checkOutput("rst_mpr_ack",  src_ack[0][1], 56'd0);
        end else begin
            checkOutput("ads_ack",  src_ack[0][0], m_ack[0]);
            checkOutput("mpr_ack",  src_ack[0][1], m_ack[1]);
            checkOutput("tx_valid", tx_valid[0], m_sending);
            checkOutput("busy",     busy[0], m_pend[0] | m_pend[1] | m_sending);
            if (m_sending) checkOutput("tx_data", tx_data[0], m_frame);

            for (int i = 0; i < 2; i++) cap[i] = src_valid[0][i] && !m_pend[i] && !m_ack[i];
            if (m_sending) begin
                if (ready[0]) begin
                    m_log.push_back(m_frame);
                    m_log_cyc.push_back(cyc);
                    m_pend[m_grant] = 1'b0;
                    m_seq[m_grant]  = m_seq[m_grant] + 6'd1;
                    m_sending = 1'b0;
                end
            end else if (enable[0] && (m_pend[0] || m_pend[1])) begin
                if (m_pend[0] && m_pend[1]) g = (m_last == 0) ? 1 : 0;
                else if (m_pend[0])         g = 0;
                else                        g = 1;
                m_grant = g; m_last = g;
                m_frame = {ids[g], m_seq[g], m_buf[g]};
                m_sending = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (cap[i]) begin
                    m_buf[i]  = src_data[0][i];
                    m_pend[i] = 1'b1;
                end
                m_ack[i] = cap[i];
            end
        end
    end

    // Transfer log of the priority instance, and an ADS ack counter for
    // the round-robin instance.
    logic [55:0] p_log [$];
    always @(negedge clk) begin
        if (rst[1]) p_log.delete();
        else if (tx_valid[1] && ready[1]) p_log.push_back(tx_data[1]);
        if (!rst[0] && src_ack[0][0]) ads_ack_cnt++;
    end

    task automatic applyStimulus(input int inst, input logic en, input logic rdy);
        enable[inst] = en;
        ready[inst]  = rdy;
    endtask

    task automatic doReset(input int inst);
        src_valid[inst][0] = 1'b0;
        src_valid[inst][1] = 1'b0;
        rst[inst] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst[inst] = 1'b0;
    endtask

    // Present a frame, hold valid until the ack, drop valid the cycle after.
    task automatic pushFrame(input int inst, input int src, input logic [47:0] d);
        int n;
        src_data[inst][src]  = d;
        src_valid[inst][src] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (src_ack[inst][src] !== 1'b1 && n < 300);
        checkOutput("ack_seen", src_ack[inst][src], 1'b1);
        @(posedge clk); #1;
        src_valid[inst][src] = 1'b0;
    endtask

    initial begin : stim
        int hi;
        int a0;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; enable[k] = 1'b1; ready[k] = 1'b0;
            for (int s = 0; s < 2; s++) begin
                src_data[k][s] = '0; src_valid[k][s] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 rst[0] = 1'b0; rst[1] = 1'b0;

        checkOutput("reset_tx_data",  tx_data[0],  56'h0);
        checkOutput("reset_tx_valid", tx_valid[0], 56'h0);
        checkOutput("reset_busy",     busy[1],     56'h0);

        // Single ADS frame: ack at t+1, frame on the wire at t+2 for one cycle.
        applyStimulus(0, 1'b1, 1'b1);
        src_data[0][0] = 48'h0000_00AB_CDEF; src_valid[0][0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("lat_t1_ack",      src_ack[0][0], 56'h1);
        checkOutput("lat_t1_tx_valid", tx_valid[0],   56'h0);
        checkOutput("lat_t1_busy",     busy[0],       56'h1);
        @(posedge clk); #1;
        src_valid[0][0] = 1'b0;
        checkOutput("lat_t2_tx_valid", tx_valid[0],   56'h1);
        checkOutput("lat_t2_tx_data",  tx_data[0],    56'h40_0000_00AB_CDEF);
        checkOutput("lat_t2_ack",      src_ack[0][0], 56'h0);
        @(posedge clk); #1;
        checkOutput("lat_t3_tx_valid", tx_valid[0],   56'h0);
        checkOutput("lat_log_size",    m_log.size(),  56'd1);
        checkOutput("lat_log_frame",   m_log[0],      56'h40_0000_00AB_CDEF);

        // Simultaneous requests after reset: ADS first, then MPR, one idle cycle.
        doReset(0);
        applyStimulus(0, 1'b1, 1'b1);
        fork
            pushFrame(0, 0, 48'h1111_2222_3333);
            pushFrame(0, 1, 48'h4444_5555_6666);
        join
        repeat (4) @(posedge clk); #1;
        checkOutput("tie_log_size", m_log.size(), 56'd2);
        checkOutput("tie_first",    m_log[0], 56'h40_1111_2222_3333);
        checkOutput("tie_second",   m_log[1], 56'h80_4444_5555_6666);
        checkOutput("tie_gap",      m_log_cyc[1] - m_log_cyc[0], 56'd2);

        // Back-pressure: ready low for 20 SEND cycles, one ack only.
        applyStimulus(0, 1'b1, 1'b0);
        a0 = ads_ack_cnt;
        pushFrame(0, 0, 48'hDEAD_BEEF_0001);
        hi = 0;
        repeat (20) begin
            if (tx_valid[0]) hi++;
            @(posedge clk); #1;
        end
        checkOutput("stall_valid_cycles", hi, 56'd20);
        checkOutput("stall_still_valid",  tx_valid[0], 56'h1);
        applyStimulus(0, 1'b1, 1'b1);
        @(posedge clk); #1;
        checkOutput("stall_released", tx_valid[0], 56'h0);
        repeat (2) @(posedge clk); #1;
        checkOutput("stall_frame",     m_log[$], 56'h41_DEAD_BEEF_0001);
        checkOutput("stall_ack_count", ads_ack_cnt - a0, 56'd1);

        // ENABLE low blocks the grant; capture and ack still happen.
        applyStimulus(0, 1'b0, 1'b1);
        pushFrame(0, 1, 48'hCAFE_0000_0002);
        repeat (5) @(posedge clk); #1;
        checkOutput("en_low_blocked", tx_valid[0], 56'h0);
        checkOutput("en_low_busy",    busy[0],     56'h1);
        applyStimulus(0, 1'b1, 1'b1);
        repeat (3) @(posedge clk); #1;
        checkOutput("en_high_frame", m_log[$], 56'h81_CAFE_0000_0002);

        // ENABLE falling during SEND must not abort the frame.
        applyStimulus(0, 1'b1, 1'b0);
        pushFrame(0, 0, 48'h0000_0000_ABCD);
        applyStimulus(0, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        checkOutput("en_fall_holds", tx_valid[0], 56'h1);
        applyStimulus(0, 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;
        checkOutput("en_fall_frame", m_log[$], 56'h42_0000_0000_ABCD);
        applyStimulus(0, 1'b1, 1'b1);

        // Sequence wrap: 65 ADS frames, then one MPR frame.
        doReset(0);
        applyStimulus(0, 1'b1, 1'b1);
        for (int i = 0; i < 65; i++) pushFrame(0, 0, {16'hA5A5, 32'(i)});
        pushFrame(0, 1, 48'h0BAD_0000_0001);
        repeat (4) @(posedge clk); #1;
        checkOutput("wrap_log_size", m_log.size(), 56'd66);
        for (int i = 0; i < 65; i++) begin
            logic [7:0] eh;
            eh = 8'h40 + 8'(i % 64);
            checkOutput($sformatf("wrap_hdr%0d", i), m_log[i][55:48], eh);
        end
        checkOutput("wrap_mpr_hdr", m_log[65][55:48], 8'h80);

        // Priority instance: a tie after an ADS grant still goes to ADS.
        doReset(1);
        applyStimulus(1, 1'b1, 1'b1);
        pushFrame(1, 0, 48'h0000_0000_0A01);
        repeat (2) @(posedge clk); #1;
        applyStimulus(1, 1'b0, 1'b1);
        fork
            pushFrame(1, 0, 48'h0000_0000_0A02);
            pushFrame(1, 1, 48'h0000_0000_0B01);
        join
        repeat (2) @(posedge clk); #1;
        checkOutput("pri_blocked_valid", tx_valid[1], 56'h0);
        checkOutput("pri_blocked_busy",  busy[1],     56'h1);
        applyStimulus(1, 1'b1, 1'b1);
        repeat (6) @(posedge clk); #1;
        checkOutput("pri_log_size", p_log.size(), 56'd3);
        checkOutput("pri_frame0",   p_log[0], 56'h40_0000_0000_0A01);
        checkOutput("pri_frame1",   p_log[1], 56'h41_0000_0000_0A02);
        checkOutput("pri_frame2",   p_log[2], 56'h80_0000_0000_0B01);

        // Reset in the middle of SEND drops the frame immediately.
        applyStimulus(1, 1'b1, 1'b0);
        pushFrame(1, 0, 48'h0000_0000_0A03);
        checkOutput("mid_rst_pre_valid", tx_valid[1], 56'h1);
        #2 rst[1] = 1'b1;
        #1;
        checkOutput("mid_rst_valid", tx_valid[1], 56'h0);
        checkOutput("mid_rst_busy",  busy[1],     56'h0);
        checkOutput("mid_rst_data",  tx_data[1],  56'h0);
        @(posedge clk); #1 rst[1] = 1'b0;
        applyStimulus(1, 1'b1, 1'b1);
        pushFrame(1, 0, 48'h0000_0000_0A04);
        repeat (4) @(posedge clk); #1;
        checkOutput("post_rst_log_size", p_log.size(), 56'd1);
        checkOutput("post_rst_frame",    p_log[0], 56'h40_0000_0000_0A04);
        checkOutput("post_rst_idle",     tx_valid[1], 56'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
